wave_uploader: RTL and testbench

// - Writer end of the main wave memory. Receives a framed byte stream from the UART receiver and

---
 rtl/wave_pkg.sv | 22 ++
 rtl/wave_uploader_watchdog_timer.sv | 29 ++
 rtl/wave_uploader.sv | 159 +++++++++++++++
 tb/tb_wave_uploader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types for the wave upload path: FSM states, abort codes, frame sync.
package wave_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CHK  = 2'b10,
    ERR_TMO  = 2'b11
  } err_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/wave_uploader_watchdog_timer.sv
// Idle watchdog: counts cycles since the last clear, flags expiry at CYCLES-1.
module watchdog_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expire
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // a clear on the expiry cycle suppresses the flag
  assign o_expire = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/wave_uploader.sv
// Frame parser writing samples into main wave memory port A.
module wave_uploader
  import wave_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int BRAM_DEPTH     = 4096,
  parameter int WW_WIDTH       = 18,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    byte_valid_in,
  input  logic [7:0]              byte_data_in,
  output logic [WW_WIDTH-1:0]     mem_addr_out,
  output logic [SAMPLE_WIDTH-1:0] mem_data_out,
  output logic                    mem_we_out,
  output logic [WW_WIDTH-1:0]     wave_width_out,
  output logic                    upload_done_out,
  output logic                    error_out,
  output logic [1:0]              error_code_out,
  output logic                    busy_out
);

  localparam logic [WW_WIDTH-1:0] DEPTH_W = WW_WIDTH'(BRAM_DEPTH);

  state_t r_state, w_state_nx;
  err_t   r_code, w_code;

  logic [7:0]              r_xor, r_len_lo, r_lo;
  logic [15:0]             r_len, w_len_raw;
  logic [WW_WIDTH-1:0]     r_cnt, r_addr, r_ww;
  logic [WW_WIDTH-1:0]     w_len_new, w_len_ext;
  logic [SAMPLE_WIDTH-1:0] r_data;
  logic r_we, r_done, r_err;
  logic w_start, w_we, w_done, w_err;
  logic w_clear, w_expire, w_len_bad;

  assign w_len_raw = {byte_data_in, r_len_lo};
  assign w_len_new = WW_WIDTH'(w_len_raw);
  assign w_len_ext = WW_WIDTH'(r_len);
  assign w_len_bad = (w_len_raw == '0) || (w_len_new > DEPTH_W);
  assign w_clear   = byte_valid_in || (r_state == S_IDLE);

  watchdog_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_clear (w_clear),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_we       = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_code     = ERR_NONE;
    unique case (r_state)
      S_IDLE: begin
        if (byte_valid_in && byte_data_in == SYNC_BYTE) begin
          w_start    = 1'b1;
          w_state_nx = S_LEN_LO;
        end
      end
      S_LEN_LO: if (byte_valid_in) w_state_nx = S_LEN_HI;
      S_LEN_HI: begin
        if (byte_valid_in) begin
          if (w_len_bad) begin
            w_err      = 1'b1;
            w_code     = ERR_LEN;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: if (byte_valid_in) w_state_nx = S_DATA_HI;
      S_DATA_HI: begin
        if (byte_valid_in) begin
          w_we = 1'b1;
          if (r_cnt == w_len_ext - 1'b1) w_state_nx = S_CHECK;
          else                           w_state_nx = S_DATA_LO;
        end
      end
      S_CHECK: begin
        if (byte_valid_in) begin
          if (byte_data_in == r_xor) begin
            w_done = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_CHK;
          end
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_expire && r_state != S_IDLE) begin
      w_err      = 1'b1;
      w_code     = ERR_TMO;
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_xor    <= '0;
      r_len_lo <= '0;
      r_lo     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ww     <= DEPTH_W;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
    end else begin
      r_we   <= w_we;
      r_done <= w_done;
      r_err  <= w_err;
      if (w_start) begin
        r_xor  <= '0;
        r_cnt  <= '0;
        r_code <= ERR_NONE;
      end else if (byte_valid_in && r_state != S_IDLE) begin
        r_xor <= r_xor ^ byte_data_in;
      end
      if (byte_valid_in && r_state == S_LEN_LO)  r_len_lo <= byte_data_in;
      if (byte_valid_in && r_state == S_LEN_HI)  r_len    <= w_len_raw;
      if (byte_valid_in && r_state == S_DATA_LO) r_lo     <= byte_data_in;
      if (w_we) begin
        r_addr <= r_cnt;
        r_data <= SAMPLE_WIDTH'({byte_data_in, r_lo});
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_err)  r_code <= w_code;
      if (w_done) r_ww   <= w_len_ext;
    end
  end

  assign mem_addr_out    = r_addr;
  assign mem_data_out    = r_data;
  assign mem_we_out      = r_we;
  assign wave_width_out  = r_ww;
  assign upload_done_out = r_done;
  assign error_out       = r_err;
  assign error_code_out  = r_code;
  assign busy_out        = (r_state != S_IDLE);

endmodule

// File: tb/tb_wave_uploader.sv
// Directed bench for wave_uploader with a write scoreboard.
module tb_wave_uploader;

  localparam int TMO = 40;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [17:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [17:0] ww;
  logic        done;
  logic        err;
  logic [1:0]  code;
  logic        busy;

  int   n_total = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic prev_we = 1'b0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  wave_uploader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .byte_valid_in  (valid),
    .byte_data_in   (data),
    .mem_addr_out   (mem_addr),
    .mem_data_out   (mem_data),
    .mem_we_out     (mem_we),
    .wave_width_out (ww),
    .upload_done_out(done),
    .error_out      (err),
    .error_code_out (code),
    .busy_out       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (mem_we) begin
        check("we_expected", 32'(exp_q.size() != 0), 1);
        check("we_one_cycle", 32'(prev_we), 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("waddr", 32'(mem_addr), 32'(e.a));
          check("wdata", 32'(mem_data), 32'(e.d));
        end
      end
      if (done || err) check("done_err_excl", 32'(done & err), 0);
      if (done) done_cnt++;
      if (err)  err_cnt++;
      prev_we <= mem_we;
    end else begin
      prev_we <= 1'b0;
    end
  end

  task automatic put(input logic [7:0] b);
    valid = 1'b1;
    data  = b;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] len, input logic [15:0] smp[$],
                       input bit flip);
    logic [7:0] x;
    x = len[7:0] ^ len[15:8];
    put(8'hA5);
    put(len[7:0]);
    put(len[15:8]);
    for (int i = 0; i < smp.size(); i++) begin
      exp_q.push_back('{a: 18'(i), d: smp[i]});
      x = x ^ smp[i][7:0] ^ smp[i][15:8];
      put(smp[i][7:0]);
      put(smp[i][15:8]);
    end
    put(x ^ {7'd0, flip});
  endtask

  task automatic expect_end(input string tag, input int d0, input int e0,
                            input int dn, input int en);
    idle(4);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(dn));
    check({tag, "_err"}, 32'(err_cnt - e0), 32'(en));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_q"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int d0, e0;
    logic [15:0] s3[$];
    logic [7:0] x;
    s3 = '{16'h1234, 16'hABCD, 16'h0001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_ww", 32'(ww), 4096);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(code), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    d0 = done_cnt; e0 = err_cnt;
    frame(16'd3, s3, 1'b1);
    expect_end("badchk", d0, e0, 0, 1);
    check("badchk_code", 32'(code), 2);
    check("badchk_ww", 32'(ww), 4096);

    d0 = done_cnt; e0 = err_cnt;
    put(8'h00); put(8'hFF); put(8'h5A);
    frame(16'd3, s3, 1'b0);
    expect_end("good3", d0, e0, 1, 0);
    check("good3_ww", 32'(ww), 3);
    check("good3_code", 32'(code), 0);

    d0 = done_cnt; e0 = err_cnt;
    put(8'hA5); put(8'h00); put(8'h00);
    expect_end("len0", d0, e0, 0, 1);
    check("len0_code", 32'(code), 1);

    d0 = done_cnt; e0 = err_cnt;
    put(8'hA5); put(8'h01); put(8'h10);
    expect_end("len4097", d0, e0, 0, 1);
    check("len4097_code", 32'(code), 1);
    check("len4097_ww", 32'(ww), 3);

    d0 = done_cnt; e0 = err_cnt;
    frame(16'd2, '{16'hBEEF, 16'h8001}, 1'b0);
    expect_end("good2", d0, e0, 1, 0);
    check("good2_ww", 32'(ww), 2);
    check("good2_code", 32'(code), 0);

    d0 = done_cnt; e0 = err_cnt;
    put(8'hA5); put(8'h03); put(8'h00);
    exp_q.push_back('{a: 18'd0, d: 16'h1234});
    put(8'h34); put(8'h12);
    exp_q.push_back('{a: 18'd1, d: 16'hABCD});
    put(8'hCD); put(8'hAB);
    idle(TMO + 3);
    expect_end("tmo", d0, e0, 0, 1);
    check("tmo_code", 32'(code), 3);
    check("tmo_ww", 32'(ww), 2);

    d0 = done_cnt; e0 = err_cnt;
    put(8'hA5); put(8'h03); put(8'h00);
    exp_q.push_back('{a: 18'd0, d: 16'h1234});
    put(8'h34); put(8'h12);
    exp_q.push_back('{a: 18'd1, d: 16'hABCD});
    put(8'hCD); put(8'hAB);
    idle(TMO - 1);
    check("edge_busy", 32'(busy), 1);
    exp_q.push_back('{a: 18'd2, d: 16'h0001});
    put(8'h01); put(8'h00);
    x = 8'h03 ^ 8'h34 ^ 8'h12 ^ 8'hCD ^ 8'hAB ^ 8'h01;
    put(x);
    expect_end("edge", d0, e0, 1, 0);
    check("edge_ww", 32'(ww), 3);

    put(8'hA5); put(8'h03); put(8'h00); put(8'h11); put(8'h22);
    check("prerst_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(mem_we), 0);
    check("midrst_ww", 32'(ww), 4096);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_code", 32'(code), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    d0 = done_cnt; e0 = err_cnt;
    frame(16'd3, s3, 1'b0);
    expect_end("postrst", d0, e0, 1, 0);
    check("postrst_ww", 32'(ww), 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
